// File: rtl/bit_serializer_pkg.sv
// Shared serializer definitions (ser_defs): FSM state encodings reused by the
// downstream detector bench, plus the legal word-width range.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/bit_serializer_bit_counter.sv
// Bit position counter for the serializer: counts 0..WIDTH-1, flags the last
// position and the one before it so the owner can register its done pulse.
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic r,
  input  logic clr,
  input  logic en,
  output logic last,
  output logic next_last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!r) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  assign last      = (cnt == CW'(WIDTH - 1));
  assign next_last = (cnt == CW'(WIDTH - 2));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a load/ready
// handshake and emits it one bit per clk on x, LSB or MSB first.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic             state
);

  // Handshake: a word transfers at a rising edge where load=1 and ready=1.
  // load while ready=0 is ignored; ready rises in IDLE and in the last-bit
  // cycle so words can stream back-to-back without a gap.

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sh;
  logic             last;
  logic             next_last;
  logic             hs;
  logic             done_q;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk       (clk),
    .r         (r),
    .clr       (hs),
    .en        (state_q == SHIFT && !hs),
    .last      (last),
    .next_last (next_last)
  );

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    hs      = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        hs    = load;
        if (hs) state_d = SHIFT;
      end
      SHIFT: begin
        ready = last;
        hs    = load && last;
        if (last && !hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Zeros shift in behind the word, so x falls back to 0 once it is drained.
  always_ff @(posedge clk) begin
    if (!r) begin
      sh <= '0;
    end else if (hs) begin
      sh <= din;
    end else if (state_q == SHIFT) begin
      sh <= MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == SHIFT) && next_last;
    end
  end

  assign x     = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  assign busy  = (state_q == SHIFT);
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 shifts the LSB out first, 1 shifts the MSB out first.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port r, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port din, input, WIDTH bits: parallel word to serialize.
REQ-006 Port load, input, 1 bit: word-valid strobe, sampled at the rising edge of clk.
REQ-007 Port ready, output, 1 bit: high when a load is accepted at the next rising edge.
REQ-008 Port x, output, 1 bit, registered: serial bit stream for the downstream sequential detector.
REQ-009 Port busy, output, 1 bit, registered: high while a word is being shifted out.
REQ-010 Port done, output, 1 bit, registered: one-cycle pulse during the final bit of each word.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT.
REQ-012 In IDLE, x SHALL be 0, busy SHALL be 0 and ready SHALL be 1.
REQ-013 A handshake SHALL occur only at a rising edge where load=1 and ready=1; din SHALL be captured into the shift register at that edge.
REQ-014 In the cycle after a handshake, the state SHALL be SHIFT, busy SHALL be 1 and x SHALL present the first bit (din[0] if MSB_FIRST=0, din[WIDTH-1] if MSB_FIRST=1).
REQ-015 Each bit SHALL be held on x for exactly one clk cycle, so a word occupies exactly WIDTH consecutive cycles with no gap.
REQ-016 A bit counter of width clog2(WIDTH) SHALL count 0..WIDTH-1 in SHIFT and SHALL clear on every handshake.
REQ-017 The last-bit condition is defined as SHIFT state with counter = WIDTH-1.
REQ-018 done SHALL be 1 only in the last-bit cycle and 0 in every other cycle.
REQ-019 ready SHALL be combinational: 1 in IDLE, 1 during the last-bit cycle, 0 in every other SHIFT cycle.
REQ-020 load=1 while ready=0 SHALL be ignored; the word in progress, din capture and the counter SHALL be unaffected.
REQ-021 A handshake during the last-bit cycle SHALL start the new word in the next cycle (state stays SHIFT, counter = 0) with no idle bit between words.
REQ-022 At the end of the last-bit cycle with no handshake, the state SHALL return to IDLE, x SHALL return to 0 and busy SHALL return to 0.
REQ-023 Changes on din outside a handshake edge SHALL NOT alter x.

Reset
REQ-024 When r=0 at a rising edge of clk, the block SHALL enter IDLE with x=0, busy=0, done=0, counter=0 and the shift register cleared.
REQ-025 A reset during SHIFT SHALL abort the word immediately, with no further bits of it emitted.
REQ-026 A load asserted in the same cycle as r=0 SHALL be discarded.
REQ-027 ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-028 The state encodings (IDLE=1'b0, SHIFT=1'b1) SHALL be shared localparams in a common include, ser_defs, for reuse by the downstream detector bench.
REQ-029 The bit counter SHALL be one sub-module, bit_counter, with ports clk, r, clr, en, and an output for the last-count flag.
REQ-030 The shift register and FSM SHALL live in bit_serializer.
REQ-031 The block SHALL contain no latches and no combinational path from load to x.

Verification
REQ-032 WIDTH=8, MSB_FIRST=0, load a single word din=8'hA5 -> x = 1,0,1,0,0,1,0,1 over 8 cycles; busy high for 8 cycles; done high in cycle 8 only; then IDLE with x=0.
REQ-033 MSB_FIRST=1, din=8'hA5 -> x = 1,0,1,0,0,1,0,1 (MSB first); din=8'h80 -> x = 1,0,0,0,0,0,0,0.
REQ-034 Back-to-back: load=1 held with 8'hFF followed by 8'h00 -> 8 ones immediately followed by 8 zeros; busy never drops; done pulses at cycles 8 and 16.
REQ-035 load pulsed at bit 3 of a word in progress -> ignored; the current word completes unchanged and the FSM returns to IDLE.
REQ-036 r=0 at bit 4 of din=8'hFF -> next cycle x=0, busy=0, done=0, ready=1; after release, a new load of 8'h01 emits 1,0,0,0,0,0,0,0.
REQ-037 Integration: the serializer drives the downstream detector's x input with the detector clocked on the same clk -> the detector's z matches the reference model cycle-for-cycle for the sequences 8'hA5 and 8'h3C.
